// File: rtl/greedy_snake_dpb_w_if.sv
// Gowin_DPB channel A port bundle between the snake list writer and the BSRAM.
interface greedy_snake_dpb_w_if;
  logic        i_a_clk_en;
  logic        i_a_data_en;
  logic        i_a_wr_en;
  logic [7:0]  i_a_data;
  logic [10:0] i_a_address;
  logic [7:0]  o_a_data;

  modport master (
    output i_a_clk_en, i_a_data_en, i_a_wr_en, i_a_data, i_a_address,
    input  o_a_data
  );

  modport slave (
    input  i_a_clk_en, i_a_data_en, i_a_wr_en, i_a_data, i_a_address,
    output o_a_data
  );
endinterface

// File: rtl/greedy_snake_dpb_w.sv
// Snake body list writer: owns BSRAM channel A, advances/grows the circular body list per move tick.
// Build option SNAKE_WALL_WRAP_EN: coordinates wrap mod 16 instead of raising the sticky wall_hit.
//
// state      | meaning
// S_INIT     | write the initial body entries, one per cycle
// S_IDLE     | waiting for move_tick (busy=0)
// S_CALC     | compute new head, pick plain move / shift / direct append
// S_SHIFT_RD | read entry k, wait RD_LATENCY cycles for o_a_data
// S_SHIFT_WR | write captured entry k to slot k+1
// S_WR_HEAD  | write strobe for the new head is on the bus
// S_KICK     | render_en pulse to the channel-B reader
// S_WAIT_RD  | wait for rd_busy high then low
module greedy_snake_dpb_w #(
  parameter logic [10:0] ADDRESS_STEP_N = 11'd4,
  parameter logic [3:0]  RD_LATENCY     = 4'd3,
  parameter logic [10:0] INIT_LENGTH    = 11'd3,
  parameter logic [10:0] MAX_LENGTH     = 11'd64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        move_tick,
  input  logic [1:0]                  dir,
  input  logic                        grow,
  input  logic                        rd_busy,
  output logic                        busy,
  output logic                        render_en,
  output logic [10:0]                 list_length,
  output logic [10:0]                 list_head_addr,
  output logic                        wall_hit,
  greedy_snake_dpb_w_if.master        bram
);

  localparam logic [10:0] DATA_BEGIN_ADDRESS = 11'd4;
  localparam logic [3:0]  INIT_X = 4'd7;
  localparam logic [3:0]  INIT_Y = 4'd7;
  localparam logic [3:0]  INIT_HEAD_X = INIT_X + INIT_LENGTH[3:0] - 4'd1;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_CALC, S_SHIFT_RD, S_SHIFT_WR, S_WR_HEAD, S_KICK, S_WAIT_RD
  } state_t;

  state_t      state;
  logic [10:0] head_idx;
  logic [10:0] k_idx;
  logic [10:0] init_cnt;
  logic [3:0]  lat_cnt;
  logic [7:0]  head_pos;
  logic [1:0]  cur_dir;
  logic        grow_l;
  logic        seen_rd_busy;
  logic        a_wr_en;
  logic [10:0] a_addr;
  logic [7:0]  a_data;

  logic [3:0]  nx, ny;
  logic [7:0]  next_pos;
  logic        off_board;
  logic        grow_ok;
  logic [10:0] head_inc;
  logic [10:0] plain_idx;
  logic [10:0] wr_idx;
  logic        go_head;

  function automatic logic [10:0] addr_of(input logic [10:0] idx);
    return DATA_BEGIN_ADDRESS + idx * ADDRESS_STEP_N;
  endfunction

  assign bram.i_a_clk_en  = 1'b1;
  assign bram.i_a_data_en = 1'b1;
  assign bram.i_a_wr_en   = a_wr_en;
  assign bram.i_a_address = a_addr;
  assign bram.i_a_data    = a_data;

  always_comb begin
    nx = head_pos[7:4];
    ny = head_pos[3:0];
    case (cur_dir)
      2'd0:    ny = ny - 4'd1;
      2'd1:    ny = ny + 4'd1;
      2'd2:    nx = nx - 4'd1;
      default: nx = nx + 4'd1;
    endcase
    next_pos = {nx, ny};
`ifdef SNAKE_WALL_WRAP_EN
    off_board = 1'b0;
`else
    off_board = (cur_dir == 2'd0 && head_pos[3:0] == 4'h0) ||
                (cur_dir == 2'd1 && head_pos[3:0] == 4'hF) ||
                (cur_dir == 2'd2 && head_pos[7:4] == 4'h0) ||
                (cur_dir == 2'd3 && head_pos[7:4] == 4'hF);
`endif
    grow_ok   = grow_l && (list_length < MAX_LENGTH);
    head_inc  = head_idx + 11'd1;
    plain_idx = (head_inc == list_length) ? 11'd0 : head_inc;
    // go_head: this cycle issues the new-head write and commits the list update
    go_head   = 1'b0;
    wr_idx    = head_inc;
    if (state == S_CALC && !off_board) begin
      if (!grow_ok) begin
        go_head = 1'b1;
        wr_idx  = plain_idx;
      end else if (list_length - 11'd1 == head_idx) begin
        go_head = 1'b1;
      end
    end else if (state == S_SHIFT_WR && !(k_idx > head_inc)) begin
      go_head = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_INIT;
      busy           <= 1'b1;
      render_en      <= 1'b0;
      wall_hit       <= 1'b0;
      a_wr_en        <= 1'b0;
      a_addr         <= 11'd0;
      a_data         <= 8'd0;
      list_length    <= INIT_LENGTH;
      list_head_addr <= addr_of(INIT_LENGTH - 11'd1);
      head_idx       <= INIT_LENGTH - 11'd1;
      head_pos       <= {INIT_HEAD_X, INIT_Y};
      cur_dir        <= 2'd3;
      k_idx          <= 11'd0;
      init_cnt       <= 11'd0;
      lat_cnt        <= 4'd0;
      grow_l         <= 1'b0;
      seen_rd_busy   <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          if (init_cnt < INIT_LENGTH) begin
            a_wr_en  <= 1'b1;
            a_addr   <= addr_of(init_cnt);
            a_data   <= {INIT_X + init_cnt[3:0], INIT_Y};
            init_cnt <= init_cnt + 11'd1;
          end else begin
            a_wr_en   <= 1'b0;
            render_en <= 1'b1;
            state     <= S_KICK;
          end
        end
        S_IDLE: begin
          if (move_tick && !wall_hit) begin
            busy   <= 1'b1;
            grow_l <= grow;
            // a 180-degree reversal keeps the current heading
            if (dir != (cur_dir ^ 2'd1)) cur_dir <= dir;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (off_board) begin
            wall_hit <= 1'b1;
            busy     <= 1'b0;
            state    <= S_IDLE;
          end else if (!go_head) begin
            k_idx   <= list_length - 11'd1;
            a_addr  <= addr_of(list_length - 11'd1);
            lat_cnt <= RD_LATENCY - 4'd1;
            state   <= S_SHIFT_RD;
          end
        end
        S_SHIFT_RD: begin
          if (lat_cnt == 4'd0) begin
            a_wr_en <= 1'b1;
            a_addr  <= addr_of(k_idx + 11'd1);
            a_data  <= bram.o_a_data;
            state   <= S_SHIFT_WR;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        S_SHIFT_WR: begin
          a_wr_en <= 1'b0;
          if (!go_head) begin
            k_idx   <= k_idx - 11'd1;
            a_addr  <= addr_of(k_idx - 11'd1);
            lat_cnt <= RD_LATENCY - 4'd1;
            state   <= S_SHIFT_RD;
          end
        end
        S_WR_HEAD: begin
          a_wr_en   <= 1'b0;
          render_en <= 1'b1;
          state     <= S_KICK;
        end
        S_KICK: begin
          render_en    <= 1'b0;
          seen_rd_busy <= rd_busy;
          state        <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (rd_busy) begin
            seen_rd_busy <= 1'b1;
          end else if (seen_rd_busy) begin
            seen_rd_busy <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_INIT;
      endcase

      if (go_head) begin
        a_wr_en        <= 1'b1;
        a_addr         <= addr_of(wr_idx);
        a_data         <= next_pos;
        head_idx       <= wr_idx;
        head_pos       <= next_pos;
        list_head_addr <= addr_of(wr_idx);
        list_length    <= list_length + {10'd0, grow_ok};
        state          <= S_WR_HEAD;
      end
    end
  end

endmodule
